instr_fetch_feeder: RTL and testbench

Instruction supply side of the core's instruction port. Fetches sequential words from instruction memory into a small prefetch queue and presents one instruction per cycle to the decode stage. Obeys the core's stall/flush contract: hold while stalled, zero after a flush, only supported opcodes. Sits between the instruction memory port and the core's `instruction` input.

---
 rtl/rv_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_feeder_if.sv | 9 +
 rtl/fetch_fifo.sv | 36 +++
 rtl/instr_fetch_feeder.sv | 66 ++++++
 tb/tb_instr_fetch_feeder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: supported opcodes, legality check and prefetch queue entry type
package rv_fetch_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ZERO   = 7'b0000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        illegal;
  } fetch_entry_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_BRANCH, OP_OP, OP_OPIMM, OP_AUIPC,
                      OP_JALR, OP_JAL, OP_STORE, OP_LUI, OP_ZERO};
  endfunction
endpackage

// File: rtl/instr_fetch_feeder_if.sv
// instr_fetch_feeder_if: instruction memory request/response port
interface instr_fetch_feeder_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_rvalid, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_rvalid, mem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == (AW+1)'(DEPTH)));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/instr_fetch_feeder.sv
// instr_fetch_feeder: credit-limited prefetch of sequential words into a queue feeding decode
module instr_fetch_feeder
  import rv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [31:0]                 flush_pc,
  instr_fetch_feeder_if.master        mem,
  output logic [31:0]                 instruction,
  output logic [31:0]                 instr_pc,
  output logic                        illegal_opcode,
  output logic                        fetch_empty
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count, outstanding, discard;
  logic [31:0]   fetch_pc, resp_pc;
  logic          push, pop, legal;
  fetch_entry_t  din, head;

  assign mem.mem_req  = !flush && (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign mem.mem_addr = fetch_pc;
  assign fetch_empty  = count == '0;
  assign push  = mem.mem_rvalid && discard == '0 && !flush;
  assign pop   = stall && !flush && !fetch_empty;
  assign legal = opcode_legal(mem.mem_rdata[6:0]);
  assign din   = '{pc: resp_pc, word: legal ? mem.mem_rdata : '0, illegal: !legal};

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk), .reset(reset), .clear(flush), .push(push), .din(din),
    .pop(pop), .dout(head), .count(count)
  );

  // resp_pc follows kept responses only; after a flush every older reply is discarded
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      discard        <= '0;
      instruction    <= '0;
      instr_pc       <= RESET_PC;
      illegal_opcode <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(mem.mem_req) - CW'(mem.mem_rvalid);
      fetch_pc    <= flush ? flush_pc : mem.mem_req ? fetch_pc + 32'd4 : fetch_pc;
      if (flush) begin
        resp_pc        <= flush_pc;
        discard        <= outstanding - CW'(mem.mem_rvalid);
        instruction    <= '0;
        illegal_opcode <= 1'b0;
      end else begin
        if (mem.mem_rvalid && discard != '0) discard <= discard - CW'(1);
        if (push) resp_pc <= resp_pc + 32'd4;
        if (stall) begin
          instruction    <= pop ? head.word : '0;
          illegal_opcode <= pop && head.illegal;
          if (pop) instr_pc <= head.pc;
        end
      end
    end
endmodule

// File: tb/tb_instr_fetch_feeder.sv
// tb_instr_fetch_feeder: directed checks of fetch, stall hold, flush, opcode filter and wrap
module tb_instr_fetch_feeder;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] flush_pc, instruction, instr_pc;
  logic        illegal_opcode, fetch_empty;
  int          passed = 0, total = 0;
  int          lat = 1;
  logic        mode13 = 1'b1, hold = 1'b0;
  logic [31:0] bad_addr = 32'h1;
  logic        pv [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] pa [3] = '{32'h0, 32'h0, 32'h0};

  instr_fetch_feeder_if m();

  instr_fetch_feeder #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .mem(m), .instruction(instruction), .instr_pc(instr_pc),
    .illegal_opcode(illegal_opcode), .fetch_empty(fetch_empty)
  );

  always #5 clk = ~clk;

  // memory with fixed latency lat; hold swallows new requests without answering
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 3; i++) pv[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[2] <= 1'b0;
      if (m.mem_req && !hold) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= m.mem_addr;
      end
    end

  assign m.mem_rvalid = pv[0];
  assign m.mem_rdata  = (pa[0] == bad_addr) ? 32'hFFFF_FFFF :
                        mode13 ? 32'h0000_0013 : {pa[0][24:0], 7'h13};

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input int l);
    reset = 1'b1;
    stall = 1'b1;
    flush = 1'b0;
    step();
    lat = l;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b1; flush = 1'b0; flush_pc = '0;
    step();
    step();
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_ill", {31'b0, illegal_opcode}, 32'h0);
    chk("rst_empty", {31'b0, fetch_empty}, 32'h1);
    reset = 1'b0;
    #1;
    // steady stream of 0x13 with 1-cycle memory
    for (int k = 0; k < 8; k++) begin
      chk("s_req", {31'b0, m.mem_req}, 32'h1);
      chk("s_addr", m.mem_addr, 4 * k);
      chk("s_instr", instruction, k >= 3 ? 32'h13 : 32'h0);
      if (k >= 3) chk("s_pc", instr_pc, 4 * (k - 3));
      if (k < 7) step();
    end
    // decode holds for 5 cycles, queue fills, then resumes without loss
    mode13 = 1'b0;
    stall = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      step();
      chk("h_instr", instruction, 32'h13);
      chk("h_pc", instr_pc, 32'd16);
      if (c >= 9) chk("h_req", {31'b0, m.mem_req}, 32'h0);
    end
    stall = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("r_pc", instr_pc, 20 + 4 * j);
      chk("r_instr", instruction, j == 0 ? 32'h13 : f(20 + 4 * j));
    end
    // flush with two requests in flight on 3-cycle memory
    restart(3);
    step();
    step();
    chk("f_req_pre", m.mem_addr, 32'h8);
    flush = 1'b1;
    flush_pc = 32'h100;
    #1;
    chk("f_req_off", {31'b0, m.mem_req}, 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("f_instr0", instruction, 32'h0);
    chk("f_req", {31'b0, m.mem_req}, 32'h1);
    chk("f_addr", m.mem_addr, 32'h100);
    for (int c = 4; c <= 6; c++) begin
      step();
      chk("f_empty", {31'b0, fetch_empty}, 32'h1);
      chk("f_bubble", instruction, 32'h0);
    end
    step();
    step();
    chk("f_first_pc", instr_pc, 32'h100);
    chk("f_first_instr", instruction, f(32'h100));
    step();
    chk("f_second_pc", instr_pc, 32'h104);
    // unsupported word at 0x14 presented as zero with illegal tag
    bad_addr = 32'h14;
    restart(1);
    for (int k = 0; k <= 10; k++) begin
      if (k >= 3) begin
        chk("i_pc", instr_pc, 4 * (k - 3));
        chk("i_instr", instruction, (4 * (k - 3) == 32'h14) ? 32'h0 : f(4 * (k - 3)));
        chk("i_ill", {31'b0, illegal_opcode}, (4 * (k - 3) == 32'h14) ? 32'h1 : 32'h0);
      end
      if (k < 10) step();
    end
    // memory stops answering: queue drains, then bubbles
    hold = 1'b1;
    step();
    chk("w_pc11", instr_pc, 32'd32);
    step();
    chk("w_pc12", instr_pc, 32'd36);
    chk("w_instr12", instruction, f(32'd36));
    chk("w_empty12", {31'b0, fetch_empty}, 32'h1);
    for (int c = 13; c <= 17; c++) begin
      step();
      chk("w_bubble", instruction, 32'h0);
      chk("w_empty", {31'b0, fetch_empty}, 32'h1);
      chk("w_pc", instr_pc, 32'd36);
    end
    chk("w_req", {31'b0, m.mem_req}, 32'h0);
    // flush while decode holds, redirect near top of address space
    hold = 1'b0;
    bad_addr = 32'h1;
    restart(1);
    for (int k = 0; k < 5; k++) step();
    chk("x_pc_pre", instr_pc, 32'd8);
    chk("x_instr_pre", instruction, f(32'd8));
    stall = 1'b0;
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFF8;
    #1;
    chk("x_req_off", {31'b0, m.mem_req}, 32'h0);
    step();
    flush = 1'b0;
    stall = 1'b1;
    #1;
    chk("x_instr0", instruction, 32'h0);
    chk("x_ill0", {31'b0, illegal_opcode}, 32'h0);
    chk("x_pc_hold", instr_pc, 32'd8);
    chk("x_addr6", m.mem_addr, 32'hFFFF_FFF8);
    step();
    chk("x_addr7", m.mem_addr, 32'hFFFF_FFFC);
    step();
    chk("x_addr8", m.mem_addr, 32'h0);
    step();
    chk("x_pc9", instr_pc, 32'hFFFF_FFF8);
    chk("x_instr9", instruction, f(32'hFFFF_FFF8));
    step();
    chk("x_pc10", instr_pc, 32'hFFFF_FFFC);
    step();
    chk("x_pc11", instr_pc, 32'h0);
    chk("x_instr11", instruction, 32'h13);
    step();
    chk("x_pc12", instr_pc, 32'h4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
